// File: rtl/riscv_mc_ctrl.sv
// Multicycle RV32I main controller: Moore FSM sequencing a shared memory port, ALU and immediate extender.
// Latency: lw 5, sw 4, R/I-ALU 4, jal 4, beq 3 cycles with mem_ready high; each low mem_ready cycle adds one.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold with mem_req asserted until mem_ready completes the access.
module riscv_mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_control,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_ILLEGAL  = 4'd11;

  logic [3:0] state, state_nx;
  logic       retire;
  logic       pc_update, branch;
  logic [1:0] alu_op;
  logic       mem_req_s, mem_write_s, ir_write_s, reg_write_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nx;
  end

  // Next-state selection; retire marks every transition that completes an instruction
  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    case (state)
      S_FETCH:    if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_R:         state_nx = S_EXECR;
          OP_I:         state_nx = S_EXECI;
          OP_BEQ:       state_nx = S_BEQ;
          OP_JAL:       state_nx = S_JAL;
          default:      state_nx = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_nx = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_nx = S_MEMWB;
      S_MEMWB:    begin state_nx = S_FETCH; retire = 1'b1; end
      S_MEMWRITE: if (mem_ready) begin state_nx = S_FETCH; retire = 1'b1; end
      S_EXECR:    state_nx = S_ALUWB;
      S_EXECI:    state_nx = S_ALUWB;
      S_ALUWB:    begin state_nx = S_FETCH; retire = 1'b1; end
      S_BEQ:      begin state_nx = S_FETCH; retire = 1'b1; end
      S_JAL:      state_nx = S_ALUWB;
      S_ILLEGAL:  state_nx = S_ILLEGAL;
      default:    state_nx = S_FETCH;
    endcase
  end

  // Moore outputs per state; FETCH qualifies its strobes with mem_ready so a stalled fetch loads nothing
  always_comb begin
    mem_req_s   = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    adr_src     = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req_s  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_s = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      S_MEMREAD:  begin mem_req_s = 1'b1; adr_src = 1'b1; end
      S_MEMWB:    begin result_src = 2'b01; reg_write_s = 1'b1; end
      S_MEMWRITE: begin mem_req_s = 1'b1; mem_write_s = 1'b1; adr_src = 1'b1; end
      S_EXECR:    begin alu_src_a = 2'b10; alu_op = 2'b10; end
      S_EXECI:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 2'b10; end
      S_ALUWB:    reg_write_s = 1'b1;
      S_BEQ:      begin alu_src_a = 2'b10; alu_op = 2'b01; branch = 1'b1; end
      S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_update = 1'b1; end
      default:    ;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // ALU operation: fixed add/sub, or function decode from funct3 (sub only for R-type with funct7b5)
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // Retired-instruction counter and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
      illegal <= 1'b0;
    end else begin
      if (retire)                 instret <= instret + CNT_W'(1);
      if (state_nx == S_ILLEGAL)  illegal <= 1'b1;
    end
  end

  // Strobes are held off while reset is asserted, even though the state already reads FETCH
  assign mem_req   = mem_req_s   & rst_n;
  assign mem_write = mem_write_s & rst_n;
  assign ir_write  = ir_write_s  & rst_n;
  assign reg_write = reg_write_s & rst_n;
  assign pc_write  = (pc_update | (branch & zero)) & rst_n;
  assign state_o   = state;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
module tb_riscv_mc_ctrl;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IA  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // Step names in the order the instruction walk-through lists them
  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5;
  localparam int EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9, JAL = 10, ILL = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  op = LW;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [3:0]  state_o;
  logic [31:0] instret;

  riscv_mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal),
    .state_o(state_o), .instret(instret)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  int          m_st = FETCH;
  logic [31:0] m_instret = 32'd0;
  bit          m_illegal = 1'b0;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] rs, a, b, imm;
    logic [2:0] alu;
  } exp_t;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Expected outputs for one cycle, read directly off the per-step output lists
  function automatic exp_t model(input int st, input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z, input logic rdy, input logic rst);
    exp_t e;
    int   aop;
    bit   pcu, br;
    e = '0; aop = 0; pcu = 0; br = 0;
    if (rst) st = FETCH;
    e.st = 4'(st);
    if (o == SW) e.imm = 2'b01;
    else if (o == BQ) e.imm = 2'b10;
    else if (o == JL) e.imm = 2'b11;
    else e.imm = 2'b00;
    case (st)
      FETCH:    begin e.mem_req = 1; e.b = 2; e.rs = 2; e.ir_write = rdy; pcu = rdy; end
      DECODE:   begin e.a = 1; e.b = 1; end
      MEMADR:   begin e.a = 2; e.b = 1; end
      MEMREAD:  begin e.mem_req = 1; e.adr_src = 1; end
      MEMWB:    begin e.rs = 1; e.reg_write = 1; end
      MEMWRITE: begin e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; end
      EXECR:    begin e.a = 2; e.b = 0; aop = 2; end
      EXECI:    begin e.a = 2; e.b = 1; aop = 2; end
      ALUWB:    e.reg_write = 1;
      BEQ:      begin e.a = 2; aop = 1; br = 1; end
      JAL:      begin e.a = 1; e.b = 2; pcu = 1; end
      default:  ;
    endcase
    e.pc_write = pcu | (br & z);
    if (aop == 1) e.alu = 3'b001;
    else if (aop == 2) begin
      if (f3 == 3'b000)      e.alu = (o[5] & f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) e.alu = 3'b101;
      else if (f3 == 3'b110) e.alu = 3'b011;
      else if (f3 == 3'b111) e.alu = 3'b010;
      else                   e.alu = 3'b000;
    end
    if (rst) begin
      e.mem_req = 0; e.mem_write = 0; e.ir_write = 0; e.pc_write = 0; e.reg_write = 0;
    end
    return e;
  endfunction

  // Single compare process: every enabled cycle, all outputs against the model
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (chk_en) begin
      e = model(m_st, op, funct3, funct7b5, zero, mem_ready, !rst_n);
      cmp("state_o",     32'(state_o),     32'(e.st));
      cmp("mem_req",     32'(mem_req),     32'(e.mem_req));
      cmp("mem_write",   32'(mem_write),   32'(e.mem_write));
      cmp("adr_src",     32'(adr_src),     32'(e.adr_src));
      cmp("ir_write",    32'(ir_write),    32'(e.ir_write));
      cmp("pc_write",    32'(pc_write),    32'(e.pc_write));
      cmp("reg_write",   32'(reg_write),   32'(e.reg_write));
      cmp("result_src",  32'(result_src),  32'(e.rs));
      cmp("alu_src_a",   32'(alu_src_a),   32'(e.a));
      cmp("alu_src_b",   32'(alu_src_b),   32'(e.b));
      cmp("imm_src",     32'(imm_src),     32'(e.imm));
      cmp("alu_control", 32'(alu_control), 32'(e.alu));
      cmp("illegal",     32'(illegal),     32'(m_illegal));
      cmp("instret",     instret,          m_instret);
    end
  end

  // One driven cycle of the current instruction at the given step
  task automatic step(input logic [6:0] o, input logic [2:0] f, input logic f7, input logic z,
                      input int st, input logic rdy, input int lit_alu);
    @(negedge clk);
    chk_en = 1'b1;
    rst_n = 1'b1;
    op = o; funct3 = f; funct7b5 = f7; zero = z; mem_ready = rdy;
    m_st = st;
    if (st == ILL) m_illegal = 1'b1;
    if (lit_alu >= 0 && (st == EXECR || st == EXECI || st == BEQ)) begin
      #1;
      cmp("lit_alu", 32'(alu_control), 32'(lit_alu));
    end
  endtask

  // One whole instruction: fetch stalls, the opcode's step list, memory stalls, then retirement
  task automatic run(input logic [6:0] o, input logic [2:0] f, input logic f7, input logic z,
                     input int fst, input int mst, input int lit_alu);
    int q[$];
    bit r[$];
    for (int i = 0; i < fst; i++) begin q.push_back(FETCH); r.push_back(1'b0); end
    q.push_back(FETCH); r.push_back(1'b1);
    q.push_back(DECODE); r.push_back(1'b1);
    case (o)
      LW: begin
        q.push_back(MEMADR); r.push_back(1'b1);
        for (int i = 0; i < mst; i++) begin q.push_back(MEMREAD); r.push_back(1'b0); end
        q.push_back(MEMREAD); r.push_back(1'b1);
        q.push_back(MEMWB); r.push_back(1'b1);
      end
      SW: begin
        q.push_back(MEMADR); r.push_back(1'b1);
        for (int i = 0; i < mst; i++) begin q.push_back(MEMWRITE); r.push_back(1'b0); end
        q.push_back(MEMWRITE); r.push_back(1'b1);
      end
      RT: begin q.push_back(EXECR); r.push_back(1'b1); q.push_back(ALUWB); r.push_back(1'b1); end
      IA: begin q.push_back(EXECI); r.push_back(1'b1); q.push_back(ALUWB); r.push_back(1'b1); end
      BQ: begin q.push_back(BEQ); r.push_back(1'b1); end
      JL: begin q.push_back(JAL); r.push_back(1'b1); q.push_back(ALUWB); r.push_back(1'b1); end
      default: for (int i = 0; i < 10; i++) begin q.push_back(ILL); r.push_back(i[0]); end
    endcase
    foreach (q[i]) step(o, f, f7, z, q[i], r[i], lit_alu);
    @(posedge clk);
    if (o == LW || o == SW || o == RT || o == IA || o == BQ || o == JL) m_instret++;
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_en = 1'b1;
      rst_n = 1'b0; op = LW; mem_ready = 1'b1;
      m_st = FETCH; m_instret = 32'd0; m_illegal = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hold_reset(2);
    #1;
    cmp("lit_rst_state", 32'(state_o), 32'd0);
    cmp("lit_rst_mem_req", 32'(mem_req), 32'd0);
    cmp("lit_rst_instret", instret, 32'd0);

    run(LW, 3'b000, 1'b0, 1'b0, 0, 0, -1);
    #1;
    cmp("lit_instret_lw", instret, 32'd1);
    run(RT, 3'b000, 1'b0, 1'b0, 3, 0, 0);
    run(BQ, 3'b000, 1'b0, 1'b1, 0, 0, 1);
    run(BQ, 3'b000, 1'b0, 1'b0, 0, 0, 1);
    run(RT, 3'b000, 1'b1, 1'b0, 0, 0, 1);
    run(IA, 3'b000, 1'b1, 1'b0, 0, 0, 0);
    run(RT, 3'b010, 1'b0, 1'b0, 0, 0, 5);
    run(IA, 3'b111, 1'b0, 1'b1, 0, 0, 2);
    run(RT, 3'b110, 1'b0, 1'b0, 0, 0, 3);
    run(IA, 3'b001, 1'b1, 1'b0, 0, 0, 0);
    run(LW, 3'b010, 1'b0, 1'b0, 1, 2, -1);
    run(SW, 3'b010, 1'b0, 1'b0, 0, 3, -1);
    run(JL, 3'b000, 1'b0, 1'b1, 2, 0, -1);
    #1;
    cmp("lit_instret_13", instret, 32'd13);

    run(BAD, 3'b000, 1'b0, 1'b0, 0, 0, -1);
    #1;
    cmp("lit_illegal", 32'(illegal), 32'd1);
    cmp("lit_ill_state", 32'(state_o), 32'd11);
    cmp("lit_ill_instret", instret, 32'd13);

    // Reset while a store is waiting on memory
    hold_reset(2);
    step(SW, 3'b010, 1'b0, 1'b0, FETCH, 1'b1, -1);
    step(SW, 3'b010, 1'b0, 1'b0, DECODE, 1'b1, -1);
    step(SW, 3'b010, 1'b0, 1'b0, MEMADR, 1'b1, -1);
    step(SW, 3'b010, 1'b0, 1'b0, MEMWRITE, 1'b0, -1);
    step(SW, 3'b010, 1'b0, 1'b0, MEMWRITE, 1'b0, -1);
    #1;
    cmp("lit_mw_wait", 32'(mem_write), 32'd1);
    @(negedge clk);
    rst_n = 1'b0; op = LW; mem_ready = 1'b1;
    m_st = FETCH; m_instret = 32'd0; m_illegal = 1'b0;
    #1;
    cmp("lit_async_state", 32'(state_o), 32'd0);
    cmp("lit_async_mem_write", 32'(mem_write), 32'd0);
    cmp("lit_async_illegal", 32'(illegal), 32'd0);
    hold_reset(1);
    run(JL, 3'b000, 1'b0, 1'b0, 0, 0, -1);
    run(SW, 3'b000, 1'b0, 1'b0, 0, 0, -1);
    #1;
    cmp("lit_instret_after_rst", instret, 32'd2);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
- Multicycle main controller for the RV32I core.
- Sequences the shared datapath: one memory port, one ALU and the immediate extender. The extender is driven through imm_src.
- Decodes the IR opcode, funct3 and funct7[5] fields, then steps a Moore FSM through fetch, decode, execute, memory and writeback.
- Generates every mux select and write strobe, and keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of the instret retired-instruction counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
op  in  7  IR[6:0].
funct3  in  3  IR[14:12].
funct7b5  in  1  IR[30].
zero  in  1  ALU zero flag.
mem_ready  in  1  memory handshake: access completes this cycle.
mem_req  out  1  memory access request.
mem_write  out  1  store strobe.
adr_src  out  1  0 = PC, 1 = Result.
ir_write  out  1  IR/OldPC load.
pc_write  out  1  PC load.
reg_write  out  1  register file write.
result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = RD1.
alu_src_b  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4.
imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J.
alu_control  out  3  000 add, 001 sub, 101 slt, 011 or, 010 and.
illegal  out  1  sticky illegal-opcode flag.
state_o  out  4  current state encoding, for debug.
instret  out  CNT_W  count of retired instructions.

Behaviour:

Reset:
- rst_n low asynchronously forces state = FETCH(0), instret = 0, illegal = 0.
- While rst_n is low, mem_req, mem_write, ir_write, pc_write and reg_write are forced to 0.

Decode and combinational outputs:
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111. Any other value is illegal.
- imm_src is decoded from op alone in every state: lw and I-ALU give 00, sw 01, beq 10, jal 11, any other op 00.
- Internal alu_op: 00 = add, 01 = sub, 10 = function decode.
- Function decode by funct3:
  - 000: sub if op[5] & funct7b5, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - any other value: add.
- pc_write = pc_update | (branch & zero).
- Every output not listed for a state is 0.

States, outputs and transitions:
- FETCH(0): mem_req, adr_src 0, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10.
  - mem_ready=1: ir_write=1, pc_update=1, next DECODE.
  - mem_ready=0: hold FETCH, no strobes.
- DECODE(1): alu_src_a 01, alu_src_b 01, alu_op 00 (computes the branch/jump target).
  - lw or sw -> MEMADR; R -> EXECR; I-ALU -> EXECI; beq -> BEQ; jal -> JAL; any other op -> ILLEGAL.
- MEMADR(2): alu_src_a 10, alu_src_b 01, alu_op 00. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD(3): mem_req, adr_src 1, result_src 00. Hold until mem_ready=1, then MEMWB.
- MEMWB(4): result_src 01, reg_write. Next FETCH; retires.
- MEMWRITE(5): mem_req, mem_write, adr_src 1, result_src 00.
  - mem_write stays high throughout the wait.
  - On mem_ready=1: next FETCH; retires.
- EXECR(6): alu_src_a 10, alu_src_b 00, alu_op 10. Next ALUWB.
- EXECI(7): alu_src_a 10, alu_src_b 01, alu_op 10. Next ALUWB.
- ALUWB(8): result_src 00, reg_write. Next FETCH; retires.
- BEQ(9): alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00, branch. Next FETCH; retires.
- JAL(10): alu_src_a 01, alu_src_b 10, alu_op 00, result_src 00, pc_update. Next ALUWB.
- ILLEGAL(11): illegal=1 (sticky), no strobes. Holds until rst_n asserts.
- Encodings 12-15 are unreachable; if entered, next state is FETCH.

Counter and latency:
- instret increments by 1 on each retiring transition into FETCH and wraps modulo 2^CNT_W.
- Cycle counts with mem_ready held high:
  - lw: 5.
  - sw: 4.
  - R, I-ALU, beq: 3 for beq, 4 for R and I-ALU.
  - jal: 4.
- Each cycle with mem_ready low adds one cycle to the instruction.

Test Plan:
1. Reset: rst_n=0 for 2 cycles, op=0000011, mem_ready=1 -> state_o=0, all strobes 0, instret=0, illegal=0. Release rst_n -> mem_req=1, ir_write=1, pc_write=1.
2. lw, mem_ready=1 -> state_o sequence 0,1,2,3,4,0. reg_write=1 only in state 4, with result_src=01. imm_src=00. instret=1 after.
3. Fetch stall: mem_ready=0 for 3 cycles -> state_o stays 0, mem_req=1, ir_write=0, pc_write=0. Fourth cycle mem_ready=1 -> ir_write=1 and pc_write=1 for exactly that cycle.
4. beq, op=1100011: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0. In both cases alu_control=001, imm_src=10, 3 cycles.
5. ALU decode:
   - R-type funct3=000, funct7b5=1 -> alu_control=001 in EXECR.
   - I-ALU funct3=000, funct7b5=1 -> 000.
   - funct3=010 -> 101.
   - funct3=111 -> 010.
6. op=1111111 -> ILLEGAL after DECODE, illegal=1 held for 10 cycles, no strobes. rst_n pulse mid-MEMWRITE -> immediate return to FETCH with mem_write=0.
